// File: rtl/psram_arbiter_if.sv
// Shared PSRAM bus between the two requesters (flash emulation, CPU iomem) and the arbiter.
// The master modport is the arbiter's view; the slave modport is the requester/memory side.
interface psram_arbiter_if;
  logic        rq0_valid;
  logic [23:0] rq0_addr;
  logic [31:0] rq0_wdata;
  logic [3:0]  rq0_wstrb;
  logic        rq0_ready;
  logic [31:0] rq0_rdata;
  logic        rq0_err;

  logic        rq1_valid;
  logic [23:0] rq1_addr;
  logic [31:0] rq1_wdata;
  logic [3:0]  rq1_wstrb;
  logic        rq1_ready;
  logic [31:0] rq1_rdata;
  logic        rq1_err;

  logic        mem_valid;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    input  rq0_valid, rq0_addr, rq0_wdata, rq0_wstrb,
    output rq0_ready, rq0_rdata, rq0_err,
    input  rq1_valid, rq1_addr, rq1_wdata, rq1_wstrb,
    output rq1_ready, rq1_rdata, rq1_err,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    output rq0_valid, rq0_addr, rq0_wdata, rq0_wstrb,
    input  rq0_ready, rq0_rdata, rq0_err,
    output rq1_valid, rq1_addr, rq1_wdata, rq1_wstrb,
    input  rq1_ready, rq1_rdata, rq1_err,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/psram_arbiter.sv
// Two-port PSRAM arbiter: port 0 normally wins, port 1 is forced through after
// STARVE_LIMIT consecutive losses; stalled transfers are aborted after TIMEOUT cycles.
//
//   state  | meaning
//   IDLE   | no transfer; arbitrate pending requests
//   GRANT0 | port 0 owns the PSRAM bus, waiting for mem_ready or timeout
//   GRANT1 | port 1 owns the PSRAM bus, waiting for mem_ready or timeout
//   DONE0  | one-cycle rq0_ready (and rq0_err if aborted)
//   DONE1  | one-cycle rq1_ready (and rq1_err if aborted)
module psram_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              resetn,
  psram_arbiter_if.master   bus,
  output logic [7:0]        timeout_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] GRANT0 = 3'd1;
  localparam logic [2:0] GRANT1 = 3'd2;
  localparam logic [2:0] DONE0  = 3'd3;
  localparam logic [2:0] DONE1  = 3'd4;

  localparam logic [3:0]  STARVE_MAX = STARVE_LIMIT[3:0];
  localparam logic [7:0]  TO_MAX     = TIMEOUT[7:0];
  localparam logic [31:0] ABORT_DATA = 32'hDECAFBAD;

  logic [2:0]  state, state_nxt;
  logic [3:0]  starve_cnt;
  logic [7:0]  to_cnt;
  logic        err_q;
  logic [31:0] rdata0_q, rdata1_q;
  logic        granted, timed_out, finish;

  assign granted   = (state == GRANT0) || (state == GRANT1);
  assign timed_out = granted && !bus.mem_ready && (to_cnt == TO_MAX);
  assign finish    = granted && (bus.mem_ready || timed_out);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.rq0_valid && bus.rq1_valid)
          state_nxt = (starve_cnt == STARVE_MAX) ? GRANT1 : GRANT0;
        else if (bus.rq0_valid)
          state_nxt = GRANT0;
        else if (bus.rq1_valid)
          state_nxt = GRANT1;
      end
      GRANT0:  if (finish) state_nxt = DONE0;
      GRANT1:  if (finish) state_nxt = DONE1;
      DONE0,
      DONE1:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      starve_cnt    <= 4'd0;
      to_cnt        <= 8'd0;
      err_q         <= 1'b0;
      rdata0_q      <= 32'd0;
      rdata1_q      <= 32'd0;
      timeout_count <= 8'd0;
    end else begin
      state <= state_nxt;

      // Port 1 only accrues starvation when it actually lost an arbitration.
      if (state == IDLE && state_nxt == GRANT1)
        starve_cnt <= 4'd0;
      else if (state == IDLE && state_nxt == GRANT0 && bus.rq1_valid &&
               starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 4'd1;

      to_cnt <= (granted && !finish) ? to_cnt + 8'd1 : 8'd0;

      if (finish) begin
        err_q <= timed_out;
        if (state == GRANT0)
          rdata0_q <= timed_out ? ABORT_DATA : bus.mem_rdata;
        else
          rdata1_q <= timed_out ? ABORT_DATA : bus.mem_rdata;
      end

      if (timed_out && timeout_count != 8'hFF)
        timeout_count <= timeout_count + 8'd1;
    end
  end

  always_comb begin
    bus.mem_addr  = 24'd0;
    bus.mem_wdata = 32'd0;
    bus.mem_wstrb = 4'd0;
    if (state == GRANT0) begin
      bus.mem_addr  = bus.rq0_addr;
      bus.mem_wdata = bus.rq0_wdata;
      bus.mem_wstrb = bus.rq0_wstrb;
    end else if (state == GRANT1) begin
      bus.mem_addr  = bus.rq1_addr;
      bus.mem_wdata = bus.rq1_wdata;
      bus.mem_wstrb = bus.rq1_wstrb;
    end
  end

  assign bus.mem_valid = granted;
  assign bus.rq0_ready = (state == DONE0);
  assign bus.rq1_ready = (state == DONE1);
  assign bus.rq0_err   = (state == DONE0) && err_q;
  assign bus.rq1_err   = (state == DONE1) && err_q;
  assign bus.rq0_rdata = rdata0_q;
  assign bus.rq1_rdata = rdata1_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Randomized transaction-level bench for psram_arbiter with a scoreboard model
// of arbitration, completion latency, abort data and the timeout counter.
module tb_psram_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 20;
  localparam int NEVER        = 1000;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [7:0] timeout_count;

  psram_arbiter_if bus();

  psram_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus),
    .timeout_count (timeout_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        pend[2];
  logic [23:0] req_addr[2];
  logic [31:0] req_wdata[2];
  logic [3:0]  req_wstrb[2];
  logic [31:0] exp_rdata[2];
  int          starve_m = 0;
  int          tcount_m = 0;
  int          obs_w;
  int          exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 1) ? bus.rq1_ready : bus.rq0_ready;
  endfunction

  function automatic logic err(input int p);
    return (p == 1) ? bus.rq1_err : bus.rq0_err;
  endfunction

  function automatic logic [31:0] rdata(input int p);
    return (p == 1) ? bus.rq1_rdata : bus.rq0_rdata;
  endfunction

  task automatic drive_reqs();
    bus.rq0_valid = pend[0];
    bus.rq0_addr  = req_addr[0];
    bus.rq0_wdata = req_wdata[0];
    bus.rq0_wstrb = req_wstrb[0];
    bus.rq1_valid = pend[1];
    bus.rq1_addr  = req_addr[1];
    bus.rq1_wdata = req_wdata[1];
    bus.rq1_wstrb = req_wstrb[1];
  endtask

  task automatic new_req(input int p, input logic [3:0] strb);
    pend[p]      = 1'b1;
    req_addr[p]  = 24'($urandom);
    req_wdata[p] = $urandom;
    req_wstrb[p] = strb;
    drive_reqs();
  endtask

  // Arbitration rule: port 0 wins unless port 1 has already lost STARVE_LIMIT times in a row.
  task automatic pick_winner(output int w);
    if (pend[0] && pend[1]) begin
      if (starve_m == STARVE_LIMIT) begin
        starve_m = 0;
        w = 1;
      end else begin
        starve_m++;
        w = 0;
      end
    end else if (pend[1]) begin
      starve_m = 0;
      w = 1;
    end else begin
      w = 0;
    end
  endtask

  // Entered at #1 after a rising edge with the arbiter idle; the memory answers
  // in grant cycle 'lat' (0 = first cycle), or never when lat > TIMEOUT.
  task automatic do_round(input int lat, input logic [31:0] rd);
    int w;
    int cyc;
    int exp_cyc;
    bit to;
    drive_reqs();
    pick_winner(w);
    @(posedge clk); #1;
    chk("mem_valid", 32'(bus.mem_valid), 32'd1);
    chk("mem_addr", 32'(bus.mem_addr), 32'(req_addr[w]));
    chk("mem_wdata", bus.mem_wdata, req_wdata[w]);
    chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(req_wstrb[w]));
    to = (lat > TIMEOUT);
    exp_cyc = to ? TIMEOUT + 1 : lat + 1;
    cyc = 0;
    while (!rdy(w) && cyc < TIMEOUT + 8) begin
      bus.mem_ready = (cyc == lat);
      bus.mem_rdata = (cyc == lat) ? rd : $urandom;
      chk("other_ready", 32'(rdy(1 - w)), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    bus.mem_ready = 1'b0;
    chk("latency", 32'(cyc), 32'(exp_cyc));
    obs_w = bus.rq0_ready ? 0 : (bus.rq1_ready ? 1 : -1);
    if (to) begin
      exp_rdata[w] = 32'hDECAFBAD;
      if (tcount_m < 255) tcount_m++;
    end else begin
      exp_rdata[w] = rd;
    end
    chk("ready", 32'(rdy(w)), 32'd1);
    chk("other_ready_done", 32'(rdy(1 - w)), 32'd0);
    chk("err", 32'(err(w)), 32'(to));
    chk("rdata", rdata(w), exp_rdata[w]);
    chk("other_rdata", rdata(1 - w), exp_rdata[1 - w]);
    chk("mem_valid_done", 32'(bus.mem_valid), 32'd0);
    chk("timeout_count", 32'(timeout_count), 32'(tcount_m));
    pend[w] = 1'b0;
    drive_reqs();
    @(posedge clk); #1;
    chk("ready_idle", 32'(rdy(w)), 32'd0);
    chk("err_idle", 32'(err(w)), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_valid"}, 32'(bus.mem_valid), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_mem_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
    chk({tag, "_ready"}, 32'({bus.rq0_ready, bus.rq1_ready}), 32'd0);
    chk({tag, "_err"}, 32'({bus.rq0_err, bus.rq1_err}), 32'd0);
    chk({tag, "_rdata0"}, bus.rq0_rdata, 32'd0);
    chk({tag, "_rdata1"}, bus.rq1_rdata, 32'd0);
    chk({tag, "_tcount"}, 32'(timeout_count), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; req_addr[p] = '0; req_wdata[p] = '0; req_wstrb[p] = '0;
      exp_rdata[p] = '0;
    end
    drive_reqs();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    #1 resetn = 1'b0;
    #1 check_all_zero("reset");
    @(posedge clk); #1;
    resetn = 1'b1;

    // Single read on the CPU port, memory answers 3 cycles after mem_valid.
    new_req(1, 4'h0);
    req_addr[1] = 24'h000100;
    do_round(3, 32'h12345678);

    // Completion on the very last allowed cycle is a normal completion.
    new_req(0, 4'h0);
    do_round(TIMEOUT, 32'hA5A5_0F0F);

    // Spurious mem_ready while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = $urandom;
      @(posedge clk); #1;
      chk("spurious_mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("spurious_ready", 32'({bus.rq0_ready, bus.rq1_ready}), 32'd0);
      chk("spurious_rdata0", bus.rq0_rdata, exp_rdata[0]);
    end
    bus.mem_ready = 1'b0;

    // Write that never completes is aborted.
    new_req(0, 4'hF);
    do_round(NEVER, 32'h0);

    // Reset in the middle of a port-0 grant aborts silently; the held request is regranted.
    new_req(0, 4'h3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_grant", 32'(bus.mem_valid), 32'd1);
    resetn = 1'b0;
    #1 check_all_zero("midreset");
    starve_m = 0;
    tcount_m = 0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    @(posedge clk); #1;
    chk("reset_no_ready", 32'({bus.rq0_ready, bus.rq1_ready}), 32'd0);
    resetn = 1'b1;
    do_round(2, $urandom);

    // Both ports hammering with an instant memory.
    for (int i = 0; i < 10; i++) begin
      if (!pend[0]) new_req(0, 4'($urandom));
      if (!pend[1]) new_req(1, 4'($urandom));
      do_round(0, $urandom);
      chk("grant_seq", 32'(obs_w), 32'(exp_seq[i]));
    end

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      int lat;
      int r;
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 1) == 1) new_req(p, 4'($urandom));
      if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)), 4'($urandom));
      r = int'($urandom_range(0, 9));
      case (r)
        6:       lat = TIMEOUT;
        7:       lat = TIMEOUT - 1;
        8:       lat = TIMEOUT + 1;
        9:       lat = int'($urandom_range(5, TIMEOUT));
        default: lat = int'($urandom_range(0, 4));
      endcase
      do_round(lat, $urandom);
    end

    // Drain, then saturate the abort counter.
    for (int i = 0; i < 2 && (pend[0] || pend[1]); i++)
      do_round(0, $urandom);
    for (int i = 0; i < 256; i++) begin
      new_req(int'($urandom_range(0, 1)), 4'($urandom));
      do_round(NEVER, 32'h0);
    end
    chk("tcount_saturated", 32'(timeout_count), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
